seven_segment_scanner: RTL and testbench

Parametrised, time-multiplexed N-digit seven-segment display driver with a built-in clock-enable prescaler, per-frame tear-free data latching, per-digit blanking and PWM brightness control. It runs directly on the board clock, so no divided clock is needed, and sits between board-level demo logic and the LED anode and segment pins. It supersedes fixed four-digit scanners clocked from a ripple-divided clock.

---
 rtl/seven_segment_pkg.sv | 26 ++
 rtl/seven_segment_decoder.sv | 20 ++
 rtl/seven_segment_scanner.sv | 177 +++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the seven-segment scanner:
//   - SEG_W      : number of segment lines ({g,f,e,d,c,b,a})
//   - seg_t      : segment vector type
//   - SEG_TABLE  : active-high hex glyph table, entry n is the glyph for nibble n
//   - inactive_level() : pin level that means "off" for a given polarity
// -----------------------------------------------------------------------------
package seven_segment_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Glyphs 0-9, A, b, C, d, E, F in active-high {g..a} order.
  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // An active-low pin is off at 1, an active-high pin is off at 0.
  function automatic logic inactive_level(input logic active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// -----------------------------------------------------------------------------
// seven_segment_decoder
// Combinational hex nibble to active-high seven-segment glyph.
// Ports:
//   nibble : in  4      hex value to display
//   seg    : out SEG_W  active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup; every nibble value has a glyph.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
// Time-multiplexed DIGITS-digit seven-segment driver running on the board
// clock. Each digit owns a slot of DIV clocks; the first cycle of every slot is
// dead (anti-ghosting) and the remainder is PWM-gated by the brightness code.
// Inputs are latched into shadow registers only at the frame boundary, so a
// frame is always drawn from one consistent snapshot.
//
// Optional feature: define SEVEN_SEGMENT_SCANNER_LZB_EN to enable leading-zero
// blanking (computed from the values latched at each frame boundary).
//
// Ports:
//   clk      : in  1           system clock
//   rst_x    : in  1           asynchronous active-low reset
//   i_data   : in  4*DIGITS    hex nibble per digit, [4k+3:4k] is digit k
//   i_dp     : in  DIGITS      decimal-point request per digit
//   i_blank  : in  DIGITS      force digit k dark
//   i_bright : in  PWM_BITS    brightness code
//   o_seg    : out 7           segments {g,f,e,d,c,b,a}
//   o_dp     : out 1           decimal point
//   o_select : out DIGITS      digit anode select, one-hot when active
//   o_frame  : out 1           one-cycle pulse following each frame boundary
// -----------------------------------------------------------------------------
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIV        = 1024,
  parameter int PWM_BITS   = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic [PWM_BITS-1:0]   i_bright,
  output logic [SEG_W-1:0]      o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_select,
  output logic                  o_frame
);

  // The slot counter cnt (0..DIV-1) is held as {phase, step}: step counts
  // clocks inside one PWM phase and phase is cnt / STEP directly, which avoids
  // a divider when DIV is not a power of two.
  localparam int STEP   = DIV >> PWM_BITS;
  localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic                OFF        = inactive_level(ACTIVE_LOW != 0);
  localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(STEP - 1);
  localparam logic [PWM_BITS-1:0] PHASE_LAST = {PWM_BITS{1'b1}};
  localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(DIGITS - 1);

  logic [STEP_W-1:0]          step_cnt;
  logic [PWM_BITS-1:0]        phase;
  logic [SLOT_W-1:0]          slot;
  logic                       cnt_zero;
  logic                       slot_end;
  logic                       frame_end;

  logic [DIGITS-1:0][3:0]     sh_data;
  logic [DIGITS-1:0]          sh_dp;
  logic [DIGITS-1:0]          sh_blank;
  logic [PWM_BITS-1:0]        sh_bright;
  logic [DIGITS-1:0]          lzb_mask;

  seg_t                       seg_dec;
  seg_t                       seg_next;
  logic                       dp_next;
  logic [DIGITS-1:0]          sel_next;

  assign cnt_zero  = (step_cnt == {STEP_W{1'b0}}) && (phase == {PWM_BITS{1'b0}});
  assign slot_end  = (step_cnt == STEP_LAST) && (phase == PHASE_LAST);
  assign frame_end = slot_end && (slot == SLOT_LAST);

  // Prescaler and slot counter.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      step_cnt <= {STEP_W{1'b0}};
      phase    <= {PWM_BITS{1'b0}};
      slot     <= {SLOT_W{1'b0}};
    end else begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= {STEP_W{1'b0}};
        phase    <= phase + PWM_BITS'(1);   // wraps to 0 at the end of the slot
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
      if (slot_end) begin
        slot <= (slot == SLOT_LAST) ? {SLOT_W{1'b0}} : slot + SLOT_W'(1);
      end
    end
  end

  // Frame snapshot of all display inputs; blank-all at reset keeps frame one dark.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      sh_data   <= '0;
      sh_dp     <= {DIGITS{1'b0}};
      sh_blank  <= {DIGITS{1'b1}};
      sh_bright <= {PWM_BITS{1'b0}};
    end else if (frame_end) begin
      sh_data   <= i_data;
      sh_dp     <= i_dp;
      sh_blank  <= i_blank;
      sh_bright <= i_bright;
    end
  end

`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
  logic [DIGITS-1:0] lzb_next;
  logic              lzb_chain;

  // Walk from the top digit down; a zero without dp stays in the chain.
  always_comb begin
    lzb_next  = {DIGITS{1'b0}};
    lzb_chain = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lzb_chain && (i_data[4*k +: 4] == 4'h0) && !i_dp[k]) begin
        lzb_next[k] = 1'b1;
      end else begin
        lzb_chain = 1'b0;
      end
    end
  end

  // Suppression mask latched together with the frame snapshot.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      lzb_mask <= {DIGITS{1'b0}};
    end else if (frame_end) begin
      lzb_mask <= lzb_next;
    end
  end
`else
  assign lzb_mask = {DIGITS{1'b0}};
`endif

  seven_segment_decoder u_decoder (
    .nibble (sh_data[slot]),
    .seg    (seg_dec)
  );

  // Active-high view of what the current slot should show this cycle.
  always_comb begin
    sel_next = {DIGITS{1'b0}};
    seg_next = {SEG_W{1'b0}};
    dp_next  = 1'b0;
    if (!cnt_zero && (phase <= sh_bright) && !sh_blank[slot] && !lzb_mask[slot]) begin
      sel_next[slot] = 1'b1;
      seg_next       = seg_dec;
      dp_next        = sh_dp[slot];
    end else begin
      sel_next = {DIGITS{1'b0}};
      seg_next = {SEG_W{1'b0}};
      dp_next  = 1'b0;
    end
  end

  // Registered pins; XOR with OFF converts active-high to the pin polarity.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      o_seg    <= {SEG_W{OFF}};
      o_dp     <= OFF;
      o_select <= {DIGITS{OFF}};
      o_frame  <= 1'b0;
    end else begin
      o_seg    <= seg_next ^ {SEG_W{OFF}};
      o_dp     <= dp_next ^ OFF;
      o_select <= sel_next ^ {DIGITS{OFF}};
      o_frame  <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
// Bench for seven_segment_scanner with DIGITS=4, DIV=16, PWM_BITS=2,
// ACTIVE_LOW=1. A cycle-index model derives every output from the scan rules
// and is compared on each falling edge; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int DIGITS   = 4;
  localparam int DIV      = 16;
  localparam int PWM_BITS = 2;
  localparam int STEP     = DIV / (1 << PWM_BITS);
  localparam int FRAME    = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_x = 1'b1;
  logic [15:0] i_data = 16'h0000;
  logic [3:0]  i_dp = 4'h0;
  logic [3:0]  i_blank = 4'h0;
  logic [1:0]  i_bright = 2'd0;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_select;
  logic        o_frame;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int fpos = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS(DIGITS), .DIV(DIV), .PWM_BITS(PWM_BITS), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_x(rst_x), .i_data(i_data), .i_dp(i_dp), .i_blank(i_blank),
    .i_bright(i_bright), .o_seg(o_seg), .o_dp(o_dp), .o_select(o_select),
    .o_frame(o_frame)
  );

  // Active-high glyphs for hex digits 0..F.
  bit [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model state: cycle index since reset and the snapshot the display uses.
  int       n = 0;
  bit [15:0] m_data;
  bit [3:0]  m_dp, m_blank, m_sup;
  int        m_bright;
  bit [6:0]  e_seg = 7'h7F;
  bit        e_dp = 1'b1;
  bit [3:0]  e_sel = 4'hF;
  bit        e_frame = 1'b0;

  function automatic bit [3:0] lzb_of(bit [15:0] d, bit [3:0] dp);
    bit [3:0] m = 4'h0;
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
    for (int k = 3; k >= 1; k--) begin
      if (d[k*4 +: 4] != 4'h0 || dp[k]) break;
      m[k] = 1'b1;
    end
`endif
    return m;
  endfunction

  function automatic int slot_of(int idx);
    return (idx / DIV) % DIGITS;
  endfunction

  function automatic bit lit_at(int idx);
    int c = idx % DIV;
    int s = slot_of(idx);
    return (c != 0) && ((c / STEP) <= m_bright) && !m_blank[s] && !m_sup[s];
  endfunction

  // Model: outputs seen in a cycle are derived from the previous cycle's index.
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      n <= 0;
      m_data <= 16'h0000; m_dp <= 4'h0; m_blank <= 4'hF; m_sup <= 4'h0; m_bright <= 0;
      e_seg <= 7'h7F; e_dp <= 1'b1; e_sel <= 4'hF; e_frame <= 1'b0;
    end else begin
      e_sel   <= lit_at(n) ? ~(4'b0001 << slot_of(n)) : 4'hF;
      e_seg   <= lit_at(n) ? ~font[m_data[slot_of(n)*4 +: 4]] : 7'h7F;
      e_dp    <= lit_at(n) ? ~m_dp[slot_of(n)] : 1'b1;
      e_frame <= ((n % FRAME) == FRAME - 1);
      if ((n % FRAME) == FRAME - 1) begin
        m_data <= i_data; m_dp <= i_dp; m_blank <= i_blank; m_bright <= int'(i_bright);
        m_sup <= lzb_of(i_data, i_dp);
      end
      n <= n + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (o_seg !== e_seg || o_dp !== e_dp || o_select !== e_sel || o_frame !== e_frame) begin
        bad++;
        $display("FAIL model t=%0t got seg=%h dp=%b sel=%h fr=%b want seg=%h dp=%b sel=%h fr=%b",
                 $time, o_seg, o_dp, o_select, o_frame, e_seg, e_dp, e_sel, e_frame);
      end
    end
  end

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Advance to the next o_frame cycle (bounded).
  task automatic wait_frame();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_frame && k < 3 * FRAME);
    check("frame_seen", {31'd0, o_frame}, 32'd1);
    fpos = 0;
  endtask

  // Move to the cycle that shows slot s, slot cycle c of the current frame.
  task automatic goto(int s, int c);
    int t = s * DIV + c + 1;
    repeat (t - fpos) @(negedge clk);
    fpos = t;
  endtask

  task automatic count_to_frame(string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_frame && k < 200);
    check(nm, k, 64);
    fpos = 0;
  endtask

  initial begin
    #2 rst_x = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_sel", o_select, 4'hF);
    check("rst_seg", o_seg, 7'h7F);
    check("rst_dp", o_dp, 1'b1);
    check("rst_frame", o_frame, 1'b0);
    i_data = 16'h3210; i_bright = 2'd3; i_blank = 4'h0; i_dp = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_hold_sel", o_select, 4'hF);
    #1 rst_x = 1'b1;
    count_to_frame("first_frame_cycle");

    // 3210 at full brightness
    goto(0, 0);  check("s0c0_dark", o_select, 4'hF);
    goto(0, 1);  check("s0_sel", o_select, 4'hE); check("s0_seg", o_seg, 7'h40);
    goto(0, 15); check("s0c15_sel", o_select, 4'hE);
    goto(1, 5);  check("s1_sel", o_select, 4'hD); check("s1_seg", o_seg, 7'h79);
    goto(2, 3);  check("s2_seg", o_seg, 7'h24);
    goto(3, 8);  check("s3_sel", o_select, 4'h7); check("s3_seg", o_seg, 7'h30);

    // brightness 1 with dp on digit 0
    i_bright = 2'd1; i_dp = 4'h1;
    wait_frame();
    goto(0, 7); check("b1_c7_sel", o_select, 4'hE); check("b1_dp", o_dp, 1'b0);
    goto(0, 8); check("b1_c8_sel", o_select, 4'hF);
    goto(1, 4); check("b1_s1_dp", o_dp, 1'b1);

    // brightness 0, digit 1 blanked
    i_bright = 2'd0; i_blank = 4'h2; i_dp = 4'h0;
    wait_frame();
    goto(0, 3); check("b0_c3_sel", o_select, 4'hE);
    goto(0, 4); check("b0_c4_sel", o_select, 4'hF);
    goto(1, 2); check("blank_s1", o_select, 4'hF);
    goto(2, 2); check("b0_s2_sel", o_select, 4'hB);

    // tear-free update
    i_bright = 2'd3; i_blank = 4'h0; i_data = 16'h1111;
    wait_frame();
    goto(1, 5); i_data = 16'h2222;
    goto(2, 5); check("tear_mid", o_seg, 7'h79);
    goto(3, 14); check("tear_end", o_seg, 7'h79); check("tear_noframe", o_frame, 1'b0);
    wait_frame();
    check("tear_framecyc", o_seg, 7'h79);
    goto(0, 1); check("tear_new", o_seg, 7'h24);

    // leading-zero blanking
    i_data = 16'h0070;
    wait_frame();
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
    goto(0, 5); check("lzb_d0", o_seg, 7'h40);
    goto(1, 5); check("lzb_d1_sel", o_select, 4'hD); check("lzb_d1_seg", o_seg, 7'h78);
    goto(2, 5); check("lzb_d2", o_select, 4'hF);
    goto(3, 5); check("lzb_d3", o_select, 4'hF);
    i_dp = 4'h4;
    wait_frame();
    goto(2, 5); check("lzb_dp_sel", o_select, 4'hB); check("lzb_dp_seg", o_seg, 7'h40);
    check("lzb_dp_dp", o_dp, 1'b0);
    i_data = 16'h0000; i_dp = 4'h0;
    wait_frame();
    goto(0, 5); check("lzb_zero_d0", o_select, 4'hE);
    goto(1, 5); check("lzb_zero_d1", o_select, 4'hF);
`else
    goto(0, 5); check("nolzb_d0", o_seg, 7'h40);
    goto(1, 5); check("nolzb_d1", o_seg, 7'h78);
    goto(2, 5); check("nolzb_d2_sel", o_select, 4'hB); check("nolzb_d2_seg", o_seg, 7'h40);
    goto(3, 5); check("nolzb_d3_sel", o_select, 4'h7); check("nolzb_d3_seg", o_seg, 7'h40);
`endif

    // reset during slot 2
    i_data = 16'h8888; i_dp = 4'h0;
    wait_frame();
    wait_frame();
    goto(2, 5);
    check("pre_rst_sel", o_select, 4'hB);
    #1 rst_x = 1'b0;
    #1;
    check("mid_rst_sel", o_select, 4'hF);
    check("mid_rst_seg", o_seg, 7'h7F);
    check("mid_rst_dp", o_dp, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst_x = 1'b1;
    count_to_frame("rerst_frame_cycle");
    goto(0, 1); check("post_rst_new", o_seg, 7'h00);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
